sha3_seq_ctrl: RTL and testbench
================================

Name: sha3_seq_ctrl

Overview:
- Sequencer in front of sha3_core. Accepts one hash command plus a left-justified 64-bit message word stream.
- Splits the message into rate-sized blocks and drives the core's absorb handshake (din64/bitlen/hash_ready/start/flag).
- Runs squeeze rounds for long SHAKE outputs and forwards digest words on a 64-bit output stream.
- Replaces bench-level task sequencing so higher Frodo logic can hash without knowing core timing.

Parameters:
- MAX_OUT_W, 255: maximum 64-bit output words per command; sets out-counter width to 8 bits.
- SQZ_CYC, 24: cycles core_squeeze is held high per squeeze round.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, command accepted when both high
- cmd_mode  in  3  0=SHAKE128 1=SHAKE256 2=SHA3-512 3=SHA3-384 4=SHA3-256 5=SHA3-224
- cmd_bitlen  in  21  total message length in bits
- cmd_outw  in  8  output words requested; used only for modes 0/1
- msg_valid / msg_ready  in / out  1 / 1  message word handshake
- msg_data  in  64  message word; bit 63 is the first message bit
- core_mode_sel  out  3  registered cmd_mode
- core_bitlen  out  11  valid bits in the current block
- core_din64  out  64  block word to core
- core_hash_ready  out  1  block loaded
- core_start  out  1  start request
- core_flag  out  1  absorb-in-progress flag
- core_squeeze  out  1  squeeze request
- core_ready  in  1  sha3_ready
- core_valid_32  in  1  digest word valid, one word per cycle while high
- core_dout  in  64  digest word
- out_valid  out  1  digest word strobe; no backpressure
- out_data  out  64  digest word
- out_last  out  1  with final word of the command
- busy  out  1  not IDLE

Behaviour:
- Reset is synchronous and active-high on clk. All outputs reset to 0 except cmd_ready=1. State resets to IDLE.
- Rate words RW by mode: 21, 17, 9, 13, 17, 18.
- Output words OW: modes 0/1 use cmd_outw (0 is treated as 1); 512→8, 384→6, 256→4, 224→4 (word 4 passed unmasked).
- States:
  - IDLE: cmd_ready=1. On cmd accept, latch mode, rem=cmd_bitlen, OW → LOAD.
  - LOAD: core_bitlen = (rem>=RW*64) ? RW*64 : rem. Present RW words, one per cycle. Word i is taken from msg_data only if i < ceil(core_bitlen/64); otherwise it is zero and the stream is not consumed. msg_ready is high only while a consuming word is pending. The cycle stalls while msg_valid=0.
  - ARM: core_hash_ready=1. Wait for core_ready, then core_start=1.
  - START: hold core_start until core_ready=0, then core_start=0 and core_flag=1 → ABSORB.
  - ABSORB: on core_ready=1, wait one cycle, then core_flag=0 and core_hash_ready=0.
    - If the block was full (rem>=RW*64): rem-=RW*64 → LOAD.
    - Otherwise → DRAIN.
  - DRAIN: each cycle with core_valid_32=1, emit out_data=core_dout and out_valid=1; increment outcnt and rcnt.
    - outcnt==OW: assert out_last → IDLE; remaining core words are ignored.
    - rcnt==RW (block exhausted) with outcnt<OW → SQUEEZE.
  - SQUEEZE: core_squeeze=1 for SQZ_CYC cycles, then 0. Clear rcnt → DRAIN.
- Full-block messages: when the message length is an exact multiple of RW*64 (including 0), a final block with core_bitlen=0 and all-zero words is always issued; the core applies padding.
- cmd_valid is ignored while busy. Reset in any state returns to IDLE within one cycle and drops every core strobe.
- core_mode_sel is held stable from accept until return to IDLE.

Optional Feature:
- SHA3_SEQ_WDOG_EN.
- Defined: a 16-bit watchdog reloads on every state change. In ARM, START, ABSORB or DRAIN, expiry (65535 idle cycles) forces IDLE, clears all core strobes and pulses an extra output port wdog_err for one cycle.
- Undefined: no watchdog logic and no wdog_err port; the controller waits indefinitely.

Test Plan:
- Mode 4, 1280-bit message → block 1: bitlen 1088, 17 words consumed. Block 2: bitlen 192, 3 words consumed plus 14 zero words. Two starts, 4 out words, out_last on word 4.
- Mode 4, bitlen 1088 → 17 words consumed, then a second block with bitlen 0 and no words consumed. Two starts total.
- Mode 0, bitlen 0, cmd_outw 42 → one bitlen-0 block, 21 words drained, core_squeeze high for exactly 24 cycles, 21 more words. out_last on word 42.
- Mode 2, bitlen 576, msg_valid low for 5 cycles mid-block → LOAD stalls 5 cycles, word order preserved, 8 out words.
- Reset asserted in START → next cycle core_start=0, core_flag=0, cmd_ready=1. A new mode-5 command then completes with 4 words.
- cmd_valid held high during DRAIN → cmd_ready stays 0 and no second accept occurs until out_last.

Source files
------------

// File: rtl/sha3_seq_ctrl.sv
// sha3_seq_ctrl
//   Sequencer in front of sha3_core. Takes one hash command and a
//   left-justified 64-bit message word stream. It cuts the message into
//   rate-sized blocks, drives the core absorb handshake, runs squeeze rounds
//   for long SHAKE outputs and forwards digest words on a 64-bit stream.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmd_*               command request (mode, message bit length, out words)
//   msg_*               message word stream, bit 63 is the first message bit
//   core_*              sha3_core absorb/squeeze interface
//   out_valid/data/last digest word stream, no backpressure
//   busy                controller is not idle
//   dbg_state           current FSM state (state_t encoding)
//   wdog_err            one-cycle watchdog expiry pulse (SHA3_SEQ_WDOG_EN only)
//
// Optional feature macro: SHA3_SEQ_WDOG_EN (16-bit stall watchdog).
//
// Handshakes: cmd_* and msg_* use valid/ready. A transfer happens on a
// rising clk edge where both valid and ready are high; the sender holds
// data stable while valid is high and ready is low. out_valid is a strobe.
module sha3_seq_ctrl #(
  parameter int MAX_OUT_W = 255,
  parameter int SQZ_CYC   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_mode,
  input  logic [20:0] cmd_bitlen,
  input  logic [7:0]  cmd_outw,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [63:0] msg_data,
  output logic [2:0]  core_mode_sel,
  output logic [10:0] core_bitlen,
  output logic [63:0] core_din64,
  output logic        core_hash_ready,
  output logic        core_start,
  output logic        core_flag,
  output logic        core_squeeze,
  input  logic        core_ready,
  input  logic        core_valid_32,
  input  logic [63:0] core_dout,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
`ifdef SHA3_SEQ_WDOG_EN
  output logic        wdog_err,
`endif
  output logic [2:0]  dbg_state
);

  localparam int OW_W  = $clog2(MAX_OUT_W + 1);
  localparam int SQZ_W = (SQZ_CYC > 1) ? $clog2(SQZ_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ARM, ST_START, ST_ABSORB, ST_ABS_WAIT, ST_DRAIN, ST_SQUEEZE
  } state_t;

  state_t            state_q, state_n;
  logic [2:0]        mode_q, mode_n;
  logic [20:0]       rem_q, rem_n;
  logic [OW_W-1:0]   ow_q, ow_n, outcnt_q, outcnt_n;
  logic [4:0]        widx_q, widx_n, rcnt_q, rcnt_n;
  logic [SQZ_W-1:0]  sqz_q, sqz_n;

  logic [4:0]  rw;
  logic [10:0] rw_bits, blk_bits;
  logic [4:0]  nwords;
  logic        full, consume;

  function automatic logic [4:0] rate_words(input logic [2:0] m);
    case (m)
      3'd0:    return 5'd21;
      3'd1:    return 5'd17;
      3'd2:    return 5'd9;
      3'd3:    return 5'd13;
      3'd4:    return 5'd17;
      3'd5:    return 5'd18;
      default: return 5'd17;
    endcase
  endfunction

  function automatic logic [OW_W-1:0] fixed_out_words(input logic [2:0] m);
    case (m)
      3'd2:    return OW_W'(8);
      3'd3:    return OW_W'(6);
      default: return OW_W'(4);
    endcase
  endfunction

  assign rw       = rate_words(mode_q);
  assign rw_bits  = {rw, 6'b0};
  // A block is full when at least a whole rate remains; an exact multiple
  // therefore always leaves a trailing zero-length block for the padding.
  assign full     = rem_q >= 21'(rw_bits);
  assign blk_bits = full ? rw_bits : rem_q[10:0];
  assign nwords   = 5'(({1'b0, blk_bits} + 12'd63) >> 6);
  assign consume  = widx_q < nwords;

`ifdef SHA3_SEQ_WDOG_EN
  logic [15:0] wdog_q;
  logic        wdog_err_q;
  logic        wdog_fire;
  assign wdog_fire = (state_q inside {ST_ARM, ST_START, ST_ABSORB, ST_ABS_WAIT, ST_DRAIN})
                     && (wdog_q == 16'hFFFF);
  assign wdog_err  = wdog_err_q;
`endif

  always_comb begin
    state_n         = state_q;
    mode_n          = mode_q;
    rem_n           = rem_q;
    ow_n            = ow_q;
    outcnt_n        = outcnt_q;
    widx_n          = widx_q;
    rcnt_n          = rcnt_q;
    sqz_n           = sqz_q;
    cmd_ready       = 1'b0;
    msg_ready       = 1'b0;
    core_bitlen     = 11'd0;
    core_din64      = 64'd0;
    core_hash_ready = 1'b0;
    core_start      = 1'b0;
    core_flag       = 1'b0;
    core_squeeze    = 1'b0;
    out_valid       = 1'b0;
    out_data        = 64'd0;
    out_last        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          mode_n = cmd_mode;
          rem_n  = cmd_bitlen;
          widx_n = 5'd0;
          if (cmd_mode == 3'd0 || cmd_mode == 3'd1)
            ow_n = (cmd_outw == 8'd0) ? OW_W'(1) : OW_W'(cmd_outw);
          else
            ow_n = fixed_out_words(cmd_mode);
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_bitlen = blk_bits;
        msg_ready   = consume;
        core_din64  = consume ? msg_data : 64'd0;
        // Words past the message tail are zero fill and never wait on the stream.
        if (!consume || msg_valid) begin
          widx_n = widx_q + 5'd1;
          if (widx_q == rw - 5'd1) begin
            widx_n  = 5'd0;
            state_n = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        core_bitlen     = blk_bits;
        core_hash_ready = 1'b1;
        if (core_ready) state_n = ST_START;
      end
      ST_START: begin
        core_bitlen     = blk_bits;
        core_hash_ready = 1'b1;
        core_start      = 1'b1;
        if (!core_ready) state_n = ST_ABSORB;
      end
      ST_ABSORB: begin
        core_bitlen     = blk_bits;
        core_hash_ready = 1'b1;
        core_flag       = 1'b1;
        if (core_ready) state_n = ST_ABS_WAIT;
      end
      ST_ABS_WAIT: begin
        core_bitlen     = blk_bits;
        core_hash_ready = 1'b1;
        core_flag       = 1'b1;
        if (full) begin
          rem_n   = rem_q - 21'(rw_bits);
          state_n = ST_LOAD;
        end else begin
          outcnt_n = '0;
          rcnt_n   = 5'd0;
          state_n  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (core_valid_32) begin
          out_valid = 1'b1;
          out_data  = core_dout;
          outcnt_n  = outcnt_q + OW_W'(1);
          rcnt_n    = rcnt_q + 5'd1;
          if (outcnt_q + OW_W'(1) == ow_q) begin
            out_last = 1'b1;
            state_n  = ST_IDLE;
          end else if (rcnt_q + 5'd1 == rw) begin
            sqz_n   = '0;
            state_n = ST_SQUEEZE;
          end
        end
      end
      ST_SQUEEZE: begin
        core_squeeze = 1'b1;
        sqz_n        = sqz_q + SQZ_W'(1);
        if (sqz_q == SQZ_W'(SQZ_CYC - 1)) begin
          rcnt_n  = 5'd0;
          state_n = ST_DRAIN;
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef SHA3_SEQ_WDOG_EN
    if (wdog_fire) begin
      state_n         = ST_IDLE;
      core_hash_ready = 1'b0;
      core_start      = 1'b0;
      core_flag       = 1'b0;
      core_squeeze    = 1'b0;
      out_valid       = 1'b0;
      out_last        = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= 3'd0;
      rem_q    <= 21'd0;
      ow_q     <= '0;
      outcnt_q <= '0;
      widx_q   <= 5'd0;
      rcnt_q   <= 5'd0;
      sqz_q    <= '0;
    end else begin
      state_q  <= state_n;
      mode_q   <= mode_n;
      rem_q    <= rem_n;
      ow_q     <= ow_n;
      outcnt_q <= outcnt_n;
      widx_q   <= widx_n;
      rcnt_q   <= rcnt_n;
      sqz_q    <= sqz_n;
    end
  end

`ifdef SHA3_SEQ_WDOG_EN
  // Counts cycles spent in the current state; any state change reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q     <= 16'd0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= (state_n != state_q) ? 16'd0 : wdog_q + 16'd1;
      wdog_err_q <= wdog_fire;
    end
  end
`endif

  assign core_mode_sel = mode_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sha3_seq_ctrl.sv
module tb_sha3_seq_ctrl;

  localparam int SQZ = 24;
  localparam logic [2:0] S_LOAD = 3'd1, S_START = 3'd3;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_mode;
  logic [20:0] cmd_bitlen;
  logic [7:0]  cmd_outw;
  logic        msg_valid, msg_ready;
  logic [63:0] msg_data;
  logic [2:0]  core_mode_sel;
  logic [10:0] core_bitlen;
  logic [63:0] core_din64;
  logic        core_hash_ready, core_start, core_flag, core_squeeze;
  logic        core_ready, core_valid_32;
  logic [63:0] core_dout;
  logic        out_valid, out_last, busy;
  logic [63:0] out_data;
  logic [2:0]  dbg_state;
`ifdef SHA3_SEQ_WDOG_EN
  logic        wdog_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int core_bno = 0;

  sha3_seq_ctrl #(.MAX_OUT_W(255), .SQZ_CYC(SQZ)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_bitlen(cmd_bitlen), .cmd_outw(cmd_outw),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .core_mode_sel(core_mode_sel), .core_bitlen(core_bitlen), .core_din64(core_din64),
    .core_hash_ready(core_hash_ready), .core_start(core_start), .core_flag(core_flag),
    .core_squeeze(core_squeeze), .core_ready(core_ready), .core_valid_32(core_valid_32),
    .core_dout(core_dout), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy),
`ifdef SHA3_SEQ_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rate_words(input logic [2:0] m);
    int t[6] = '{21, 17, 9, 13, 17, 18};
    return (m < 3'd6) ? t[m] : 17;
  endfunction

  function automatic int out_words(input logic [2:0] m, input int outw);
    if (m <= 3'd1) return (outw == 0) ? 1 : outw;
    if (m == 3'd2) return 8;
    if (m == 3'd3) return 6;
    return 4;
  endfunction

  function automatic logic [63:0] msg_word(input int j);
    return {8'hA5, 24'(j), 32'hC0DE_0000 | 32'(j)};
  endfunction

  // Behavioural sha3_core: drops ready for a few cycles after a start, and
  // emits one rate of digest words after the final absorb and after each squeeze.
  initial begin : core_model
    int rdy_cnt, burst_left, cur_b, k;
    logic nxt_ready, prev_flag, prev_sqz;
    logic [10:0] last_bl;
    core_ready = 1'b1; core_valid_32 = 1'b0; core_dout = 64'd0;
    rdy_cnt = 0; burst_left = 0; cur_b = 0; k = 0;
    prev_flag = 1'b0; prev_sqz = 1'b0; last_bl = 11'd0;
    forever begin
      @(negedge clk);
      nxt_ready = core_ready;
      if (core_start && core_ready && rdy_cnt == 0) begin
        nxt_ready = 1'b0; rdy_cnt = 4;
      end else if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) nxt_ready = 1'b1;
      end
      if (core_flag) last_bl = core_bitlen;
      if ((prev_flag && !core_flag && int'(last_bl) < rate_words(core_mode_sel) * 64) ||
          (prev_sqz && !core_squeeze)) begin
        burst_left = rate_words(core_mode_sel); cur_b = core_bno; core_bno++; k = 0;
      end
      prev_flag = core_flag;
      prev_sqz  = core_squeeze;
      @(posedge clk); #1;
      core_ready = nxt_ready;
      if (burst_left > 0) begin
        core_valid_32 = 1'b1;
        core_dout = {24'hD16E57, 8'(cur_b), 32'(k)};
        k++; burst_left--;
      end else begin
        core_valid_32 = 1'b0;
        core_dout = 64'd0;
      end
    end
  end

  // driver + scoreboard for one command
  task automatic run_cmd(input logic [2:0] mode, input int bitlen, input int outw,
                         input int stall_at, input int stall_len, input bit hold_cmd);
    int rw, ow, nmsg, rem, sent, stall_left, blk, widx, nw, n_pres, n_out;
    int n_start, n_sqz, stall_cyc, bad_ready, bad_mode;
    logic [10:0] exp_bl_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_din, exp_w;
    logic prev_start;
    bit done;
    rw = rate_words(mode); ow = out_words(mode, outw);
    nmsg = (bitlen + 63) / 64;
    rem = bitlen;
    while (1) begin
      exp_bl_q.push_back(11'((rem >= rw * 64) ? rw * 64 : rem));
      if (rem >= rw * 64) rem -= rw * 64;
      else break;
    end
    for (int n = 0; n < ow; n++) exp_q.push_back({24'hD16E57, 8'(n / rw), 32'(n % rw)});
    sent = 0; stall_left = stall_len; blk = 0; widx = 0; n_pres = 0; n_out = 0;
    n_start = 0; n_sqz = 0; stall_cyc = 0; bad_ready = 0; bad_mode = 0;
    prev_start = 1'b0; done = 1'b0;

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_mode = mode; cmd_bitlen = 21'(bitlen); cmd_outw = 8'(outw);
    @(negedge clk);
    check_eq("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    core_bno = 0;
    if (!hold_cmd) cmd_valid = 1'b0;
    cmd_mode = ~mode; cmd_bitlen = 21'd0;

    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (sent < nmsg && sent == stall_at && stall_left > 0) begin
        msg_valid = 1'b0; msg_data = 64'hDEAD_BEEF_DEAD_BEEF; stall_left--;
      end else begin
        msg_valid = 1'b1; msg_data = msg_word(sent);
      end
      @(negedge clk);
      if (busy && cmd_ready) bad_ready++;
      if (busy && core_mode_sel != mode) bad_mode++;
      if (dbg_state == S_LOAD && msg_ready && !msg_valid) stall_cyc++;
      if (dbg_state == S_LOAD && (msg_valid || !msg_ready)) begin
        nw = (blk < exp_bl_q.size()) ? (int'(exp_bl_q[blk]) + 63) / 64 : 0;
        exp_din = (widx < nw) ? msg_word(sent) : 64'd0;
        check_eq("msg_ready", {63'd0, msg_ready}, {63'd0, (widx < nw)});
        check_eq("core_din64", core_din64, exp_din);
        if (msg_ready && msg_valid) sent++;
        n_pres++; widx++;
        if (widx == rw) begin widx = 0; blk++; end
      end
      if (core_start && !prev_start) begin
        if (n_start < exp_bl_q.size())
          check_eq("blk_bitlen", {53'd0, core_bitlen}, {53'd0, exp_bl_q[n_start]});
        n_start++;
      end
      prev_start = core_start;
      if (core_squeeze) n_sqz++;
      if (out_valid) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check_eq("out_data", out_data, exp_w);
        check_eq("out_last", {63'd0, out_last}, {63'd0, (n_out == ow - 1)});
        n_out++;
        if (out_last) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; msg_valid = 1'b0;
    check_eq("cmd_done", {63'd0, done}, 64'd1);
    check_eq("n_starts", 64'(n_start), 64'(exp_bl_q.size()));
    check_eq("n_presented", 64'(n_pres), 64'(exp_bl_q.size() * rw));
    check_eq("n_consumed", 64'(sent), 64'(nmsg));
    check_eq("n_out", 64'(n_out), 64'(ow));
    check_eq("squeeze_cycles", 64'(n_sqz), 64'(((ow - 1) / rw) * SQZ));
    check_eq("stall_cycles", 64'(stall_cyc), 64'(stall_len));
    check_eq("cmd_ready_busy", 64'(bad_ready), 64'd0);
    check_eq("mode_sel_stable", 64'(bad_mode), 64'd0);
    @(negedge clk);
    check_eq("idle_after_last", {62'd0, busy, cmd_ready}, 64'd1);
  endtask

  initial begin : main
    bit seen, taken;
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_bitlen = 21'd0; cmd_outw = 8'd0;
    msg_valid = 1'b0; msg_data = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_strobes", {58'd0, core_hash_ready, core_start, core_flag, core_squeeze,
                             out_valid, out_last}, 64'd0);
    check_eq("rst_msg_ready", {63'd0, msg_ready}, 64'd0);
    check_eq("rst_mode_sel", {61'd0, core_mode_sel}, 64'd0);
    check_eq("rst_bitlen", {53'd0, core_bitlen}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_cmd(3'd4, 1280, 7, -1, 0, 1'b0);   // two blocks: 1088 + 192
    run_cmd(3'd4, 1088, 0, -1, 0, 1'b0);   // exact rate: trailing zero block
    run_cmd(3'd0, 0, 42, -1, 0, 1'b0);     // SHAKE128 with one squeeze round
    run_cmd(3'd2, 576, 0, 4, 5, 1'b0);     // stream stall mid-block
    run_cmd(3'd3, 832, 0, -1, 0, 1'b1);    // cmd_valid held through the command
    run_cmd(3'd1, 130, 0, -1, 0, 1'b0);    // outw 0 treated as 1

    // reset while in START
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_mode = 3'd4; cmd_bitlen = 21'd64; cmd_outw = 8'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; msg_valid = 1'b1; msg_data = msg_word(0);
    seen = 1'b0; taken = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (dbg_state == S_START) seen = 1'b1;
      else begin
        if (msg_ready && msg_valid) taken = 1'b1;
        @(posedge clk); #1;
        if (taken) msg_valid = 1'b0;
      end
    end
    check_eq("reached_start", {63'd0, seen}, 64'd1);
    check_eq("start_before_rst", {63'd0, core_start}, 64'd1);
    @(posedge clk); #1 reset = 1'b1; msg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_start_drop", {61'd0, core_start, core_flag, core_hash_ready}, 64'd0);
    check_eq("rst_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);

    run_cmd(3'd5, 100, 0, -1, 0, 1'b0);    // SHA3-224 after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
